data_write_buffer: RTL and testbench

- Posted-store buffer on the CPU data path, between the core's sram-like data port (slave side, `s_`) and the sram-like-to-AXI bridge (master side, `m_`).
- Stores are acknowledged to the core after one cycle and drained to the bridge in order.
- Loads are passed through only when the buffer is empty, which preserves program order for both RAM and MMIO.
- Only one downstream transaction is outstanding at a time.

---
 rtl/dwb_pkg.sv | 30 +++
 rtl/dwb_fifo.sv | 64 ++++++
 rtl/data_write_buffer.sv | 194 +++++++++++++++++++
 tb/tb_data_write_buffer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dwb_pkg.sv
// Shared types and constants for the data write buffer.
//   state_t : buffer control states
//   SZ_*    : access size encodings used on both the core and bridge ports
//   entry_t : one posted store {addr, size, wdata}
package dwb_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DRAIN_REQ  = 3'd1,
        DRAIN_WAIT = 3'd2,
        LOAD_REQ   = 3'd3,
        LOAD_WAIT  = 3'd4
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
    } entry_t;

    // True while a load owns the downstream port; stores must wait.
    function automatic logic is_load_state(input state_t s);
        return (s == LOAD_REQ) || (s == LOAD_WAIT);
    endfunction

endpackage

// File: rtl/dwb_fifo.sv
// Synchronous FIFO holding posted stores.
//   clk, reset  : clock, synchronous active-high reset
//   push        : write push_entry (ignored when full)
//   push_entry  : entry to store
//   pop         : drop the head entry (ignored when empty)
//   head        : oldest entry, valid while count != 0
//   count       : number of occupied entries (0..DEPTH)
module dwb_fifo
    import dwb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  entry_t        push_entry,
    input  logic          pop,
    output entry_t        head,
    output logic [CW-1:0] count
);

    entry_t        mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign push_ok_s = push & (count_r != CW'(DEPTH));
    assign pop_ok_s  = pop & (count_r != {CW{1'b0}});
    assign head      = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents need no reset because count gates validity.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_entry;
        end
    end

endmodule

// File: rtl/data_write_buffer.sv
// Posted-store buffer between the core data port (s_*) and the bridge (m_*).
// Stores are acked one cycle after acceptance and drained in order; loads pass
// through only when the buffer is empty and idle. One downstream transaction
// is outstanding at a time.
//   s_req/s_wr/s_size/s_addr/s_wdata : core request
//   s_addr_ok, s_data_ok, s_rdata    : core accept / response / load data
//   m_req/m_wr/m_size/m_addr/m_wdata : bridge request
//   m_addr_ok, m_data_ok, m_rdata    : bridge accept / response / load data
module data_write_buffer
    import dwb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_req,
    input  logic        s_wr,
    input  logic [1:0]  s_size,
    input  logic [31:0] s_addr,
    input  logic [31:0] s_wdata,
    output logic        s_addr_ok,
    output logic        s_data_ok,
    output logic [31:0] s_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t        state_r;
    state_t        state_nx_s;
    logic [CW-1:0] count_s;
    entry_t        head_s;
    entry_t        push_entry_s;
    logic          store_hs_s;
    logic          load_hs_s;
    logic          pop_s;
    logic          load_rsp_s;
    logic [31:0]   load_addr_r;
    logic [1:0]    load_size_r;
    logic          s_data_ok_r;
    logic [31:0]   s_rdata_r;

    assign push_entry_s = '{addr: s_addr, size: s_size, wdata: s_wdata};

    // Core-side handshake decode; space is judged on the current count, so a pop this cycle does not help.
    always_comb begin
        store_hs_s = 1'b0;
        load_hs_s  = 1'b0;
        if (reset) begin
            store_hs_s = 1'b0;
            load_hs_s  = 1'b0;
        end else begin
            store_hs_s = s_req & s_wr & (count_s < CW'(DEPTH)) & ~is_load_state(state_r);
            load_hs_s  = s_req & ~s_wr & (count_s == {CW{1'b0}}) & (state_r == IDLE);
        end
    end

    assign s_addr_ok  = store_hs_s | load_hs_s;
    assign pop_s      = (state_r == DRAIN_REQ) & m_addr_ok;
    assign load_rsp_s = (state_r == LOAD_WAIT) & m_data_ok;

    dwb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (store_hs_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .head       (head_s),
        .count      (count_s)
    );

    // Control state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; a load can only win in IDLE when the FIFO is empty, so it never races a drain.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (load_hs_s) begin
                    state_nx_s = LOAD_REQ;
                end else if (count_s != {CW{1'b0}}) begin
                    state_nx_s = DRAIN_REQ;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            DRAIN_REQ: begin
                if (m_addr_ok) begin
                    state_nx_s = DRAIN_WAIT;
                end else begin
                    state_nx_s = DRAIN_REQ;
                end
            end
            DRAIN_WAIT: begin
                if (m_data_ok) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DRAIN_WAIT;
                end
            end
            LOAD_REQ: begin
                if (m_addr_ok) begin
                    state_nx_s = LOAD_WAIT;
                end else begin
                    state_nx_s = LOAD_REQ;
                end
            end
            LOAD_WAIT: begin
                if (m_data_ok) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = LOAD_WAIT;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Bridge request fields, driven purely from registered state so they hold until m_addr_ok.
    always_comb begin
        m_req   = 1'b0;
        m_wr    = 1'b0;
        m_size  = 2'd0;
        m_addr  = 32'd0;
        m_wdata = 32'd0;
        case (state_r)
            DRAIN_REQ: begin
                m_req   = 1'b1;
                m_wr    = 1'b1;
                m_size  = head_s.size;
                m_addr  = head_s.addr;
                m_wdata = head_s.wdata;
            end
            LOAD_REQ: begin
                m_req   = 1'b1;
                m_wr    = 1'b0;
                m_size  = load_size_r;
                m_addr  = load_addr_r;
                m_wdata = 32'd0;
            end
            default: begin
                m_req   = 1'b0;
                m_wr    = 1'b0;
                m_size  = 2'd0;
                m_addr  = 32'd0;
                m_wdata = 32'd0;
            end
        endcase
    end

    // Capture the accepted load's address and size for the LOAD_REQ phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_addr_r <= 32'd0;
            load_size_r <= 2'd0;
        end else if (load_hs_s) begin
            load_addr_r <= s_addr;
            load_size_r <= s_size;
        end
    end

    // Registered core responses: store ack one cycle after accept, load data one cycle after m_data_ok.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_data_ok_r <= 1'b0;
            s_rdata_r   <= 32'd0;
        end else begin
            s_data_ok_r <= store_hs_s | load_rsp_s;
            if (load_rsp_s) begin
                s_rdata_r <= m_rdata;
            end
        end
    end

    assign s_data_ok = s_data_ok_r;
    assign s_rdata   = s_rdata_r;

endmodule

// File: tb/tb_data_write_buffer.sv
// Directed self-checking bench for data_write_buffer with a simple bridge model.
module tb_data_write_buffer;
    import dwb_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s_req = 1'b0;
    logic        s_wr = 1'b0;
    logic [1:0]  s_size = 2'd0;
    logic [31:0] s_addr = 32'd0;
    logic [31:0] s_wdata = 32'd0;
    logic        s_addr_ok;
    logic        s_data_ok;
    logic [31:0] s_rdata;
    logic        m_req;
    logic        m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_addr_ok;
    logic        m_data_ok = 1'b0;
    logic [31:0] m_rdata;

    // bridge model controls and write log
    logic        bridge_ready = 1'b1;
    int          resp_delay = 1;
    logic [31:0] bridge_rdata = 32'd0;
    logic        br_busy = 1'b0;
    int          br_cnt = 0;
    logic [31:0] wr_addr_log [64];
    logic [31:0] wr_data_log [64];
    logic [1:0]  wr_size_log [64];
    int          wr_count = 0;

    int tests_run = 0;
    int tests_failed = 0;

    data_write_buffer #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    assign m_addr_ok = m_req & bridge_ready;
    assign m_rdata   = bridge_rdata;

    // Bridge model: logs writes, returns m_data_ok resp_delay cycles after each accepted request.
    always @(posedge clk) begin
        if (reset) begin
            br_busy   <= 1'b0;
            m_data_ok <= 1'b0;
        end else begin
            m_data_ok <= 1'b0;
            if (m_req && m_addr_ok) begin
                if (m_wr && wr_count < 64) begin
                    wr_addr_log[wr_count] <= m_addr;
                    wr_data_log[wr_count] <= m_wdata;
                    wr_size_log[wr_count] <= m_size;
                    wr_count <= wr_count + 1;
                end
                if (resp_delay <= 1) begin
                    m_data_ok <= 1'b1;
                end else begin
                    br_busy <= 1'b1;
                    br_cnt  <= resp_delay - 1;
                end
            end else if (br_busy) begin
                if (br_cnt == 1) begin
                    m_data_ok <= 1'b1;
                    br_busy   <= 1'b0;
                end else begin
                    br_cnt <= br_cnt - 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        s_req   = 1'b1;
        s_wr    = wr;
        s_addr  = a;
        s_wdata = d;
        s_size  = sz;
    endtask

    // Present a store, hold it until accepted (bounded), then drop s_req on the next cycle.
    task automatic issue_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        bit got;
        got = 1'b0;
        drive(1'b1, a, d, sz);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (s_addr_ok) begin
                got = 1'b1;
                break;
            end
            next_cycle();
        end
        if (!got) check("store_timeout", 32'd0, 32'd1);
        next_cycle();
        s_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc0;
        int ok_cyc;
        int dok_cyc;
        int found;

        // ---------------- reset ----------------
        s_req = 1'b1; s_wr = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_addr_ok", {31'd0, s_addr_ok}, 32'd0);
        check("rst_m_req", {31'd0, m_req}, 32'd0);
        check("rst_data_ok", {31'd0, s_data_ok}, 32'd0);
        check("rst_rdata", s_rdata, 32'd0);
        check("rst_m_addr", m_addr, 32'd0);
        next_cycle();
        reset = 1'b0;
        s_req = 1'b0;
        repeat (2) next_cycle();

        // ---------------- test 1: single store ----------------
        bridge_ready = 1'b1; resp_delay = 1;
        wc0 = wr_count;
        drive(1'b1, 32'h8000_0100, 32'hDEAD_BEEF, SZ_WORD);       // cycle T
        @(negedge clk);
        check("t1_addr_ok", {31'd0, s_addr_ok}, 32'd1);
        next_cycle();                                             // T+1
        s_req = 1'b0;
        @(negedge clk);
        check("t1_data_ok", {31'd0, s_data_ok}, 32'd1);
        check("t1_no_early_req", {31'd0, m_req}, 32'd0);
        next_cycle();                                             // T+2
        @(negedge clk);
        check("t1_m_req", {31'd0, m_req}, 32'd1);
        check("t1_m_wr", {31'd0, m_wr}, 32'd1);
        check("t1_m_addr", m_addr, 32'h8000_0100);
        check("t1_m_wdata", m_wdata, 32'hDEAD_BEEF);
        check("t1_m_size", {30'd0, m_size}, 32'd2);
        check("t1_single_ack", {31'd0, s_data_ok}, 32'd0);
        repeat (8) next_cycle();
        check("t1_wr_cnt", 32'(wr_count - wc0), 32'd1);
        check("t1_log_addr", wr_addr_log[wc0], 32'h8000_0100);
        check("t1_log_data", wr_data_log[wc0], 32'hDEAD_BEEF);

        // ---------------- test 2: fill, backpressure, no bypass ----------------
        bridge_ready = 1'b0;
        wc0 = wr_count;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) next_cycle();
            drive(1'b1, 32'h100 + 32'(4 * i), 32'hA000_0000 | 32'(i), SZ_WORD);
            @(negedge clk);
            check($sformatf("t2_fill%0d", i), {31'd0, s_addr_ok}, 32'd1);
        end
        next_cycle();
        drive(1'b1, 32'h110, 32'hA000_0004, SZ_WORD);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("t2_full%0d", k), {31'd0, s_addr_ok}, 32'd0);
            next_cycle();
        end
        bridge_ready = 1'b1;                                      // first pop this cycle
        @(negedge clk);
        check("t2_no_bypass", {31'd0, s_addr_ok}, 32'd0);
        check("t2_m_req", {31'd0, m_req}, 32'd1);
        next_cycle();
        @(negedge clk);
        check("t2_fifth_ok", {31'd0, s_addr_ok}, 32'd1);
        next_cycle();
        s_req = 1'b0;
        repeat (40) next_cycle();
        check("t2_wr_cnt", 32'(wr_count - wc0), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t2_addr%0d", i), wr_addr_log[wc0 + i], 32'h100 + 32'(4 * i));
            check($sformatf("t2_data%0d", i), wr_data_log[wc0 + i], 32'hA000_0000 | 32'(i));
        end

        // ---------------- test 3: store then load same address ----------------
        resp_delay = 3;
        bridge_rdata = 32'h1234_5678;
        drive(1'b1, 32'h2000, 32'h1234_5678, SZ_WORD);            // cycle T
        @(negedge clk);
        check("t3_store_ok", {31'd0, s_addr_ok}, 32'd1);
        next_cycle();
        drive(1'b0, 32'h2000, 32'd0, SZ_WORD);
        ok_cyc = -1; dok_cyc = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (m_data_ok) dok_cyc = c;
            if (s_addr_ok) begin
                ok_cyc = c;
                break;
            end
            next_cycle();
        end
        check("t3_store_dok_cyc", 32'(dok_cyc), 32'd5);
        check("t3_load_ok_cyc", 32'(ok_cyc), 32'd6);
        next_cycle();                                             // L+1
        s_req = 1'b0;
        @(negedge clk);
        check("t3_ld_m_req", {31'd0, m_req}, 32'd1);
        check("t3_ld_m_wr", {31'd0, m_wr}, 32'd0);
        check("t3_ld_m_addr", m_addr, 32'h2000);
        check("t3_ld_m_wdata", m_wdata, 32'd0);
        found = 0;
        for (int c = 0; c < 20; c++) begin
            next_cycle();
            @(negedge clk);
            if (m_data_ok) begin
                found = 1;
                break;
            end
        end
        check("t3_rsp_seen", 32'(found), 32'd1);
        check("t3_no_early_rsp", {31'd0, s_data_ok}, 32'd0);
        next_cycle();
        @(negedge clk);
        check("t3_rsp_ok", {31'd0, s_data_ok}, 32'd1);
        check("t3_rdata", s_rdata, 32'h1234_5678);
        repeat (4) next_cycle();

        // ---------------- test 4: load from empty, store blocked during load ----------------
        resp_delay = 3;
        bridge_rdata = 32'hCAFE_F00D;
        wc0 = wr_count;
        drive(1'b0, 32'h3000, 32'd0, SZ_BYTE);                   // cycle L
        @(negedge clk);
        check("t4_load_ok", {31'd0, s_addr_ok}, 32'd1);
        next_cycle();                                             // L+1
        s_req = 1'b0;
        @(negedge clk);
        check("t4_m_req", {31'd0, m_req}, 32'd1);
        check("t4_m_wr", {31'd0, m_wr}, 32'd0);
        check("t4_m_addr", m_addr, 32'h3000);
        check("t4_m_size", {30'd0, m_size}, 32'd0);
        next_cycle();                                             // L+2
        drive(1'b1, 32'h4000, 32'h55AA_55AA, SZ_WORD);
        @(negedge clk);
        check("t4_st_blk0", {31'd0, s_addr_ok}, 32'd0);
        check("t4_req_low", {31'd0, m_req}, 32'd0);
        next_cycle();                                             // L+3
        @(negedge clk);
        check("t4_st_blk1", {31'd0, s_addr_ok}, 32'd0);
        next_cycle();                                             // L+4
        @(negedge clk);
        check("t4_st_blk2", {31'd0, s_addr_ok}, 32'd0);
        check("t4_m_data_ok", {31'd0, m_data_ok}, 32'd1);
        check("t4_no_early_rsp", {31'd0, s_data_ok}, 32'd0);
        next_cycle();                                             // L+5
        @(negedge clk);
        check("t4_rsp_ok", {31'd0, s_data_ok}, 32'd1);
        check("t4_rdata", s_rdata, 32'hCAFE_F00D);
        check("t4_st_accept", {31'd0, s_addr_ok}, 32'd1);
        next_cycle();                                             // L+6
        s_req = 1'b0;
        @(negedge clk);
        check("t4_st_ack", {31'd0, s_data_ok}, 32'd1);
        repeat (12) next_cycle();
        check("t4_wr_cnt", 32'(wr_count - wc0), 32'd1);
        check("t4_log_addr", wr_addr_log[wc0], 32'h4000);

        // ---------------- test 5: reset mid-drain ----------------
        resp_delay = 10;
        wc0 = wr_count;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) next_cycle();
            drive(1'b1, 32'h5000 + 32'(4 * i), 32'hB000_0000 | 32'(i), SZ_WORD);
            @(negedge clk);
            check($sformatf("t5_fill%0d", i), {31'd0, s_addr_ok}, 32'd1);
        end
        next_cycle();                                             // 3 buffered, DRAIN_WAIT
        s_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("t5_one_drained", 32'(wr_count - wc0), 32'd1);
        check("t5_wait_req", {31'd0, m_req}, 32'd0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("t5_m_req", {31'd0, m_req}, 32'd0);
        check("t5_data_ok", {31'd0, s_data_ok}, 32'd0);
        found = 0;
        for (int c = 0; c < 20; c++) begin
            next_cycle();
            @(negedge clk);
            if (m_req) found = 1;
        end
        check("t5_no_req", 32'(found), 32'd0);
        check("t5_no_more_wr", 32'(wr_count - wc0), 32'd1);
        resp_delay = 1;
        next_cycle();
        drive(1'b0, 32'h6000, 32'd0, SZ_HALF);                   // accepted only if count==0
        @(negedge clk);
        check("t5_empty_load_ok", {31'd0, s_addr_ok}, 32'd1);
        next_cycle();
        s_req = 1'b0;
        repeat (8) next_cycle();

        // ---------------- test 6: pointer wrap streaming ----------------
        bridge_ready = 1'b1; resp_delay = 1;
        wc0 = wr_count;
        for (int i = 0; i < 16; i++) begin
            issue_store(32'h1000 + 32'(4 * i), 32'hC0DE_0000 | 32'(i * 17), SZ_WORD);
        end
        repeat (40) next_cycle();
        check("t6_wr_cnt", 32'(wr_count - wc0), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t6_addr%0d", i), wr_addr_log[wc0 + i], 32'h1000 + 32'(4 * i));
            check($sformatf("t6_data%0d", i), wr_data_log[wc0 + i], 32'hC0DE_0000 | 32'(i * 17));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
